// File: rtl/vga_timing_pkg.sv
// Timing sets and decode helpers shared by the VGA timing generator.
// Holds mode tables, total() and in_range() for the per-axis decode.
package vga_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
   } timing_t;

   localparam timing_t T_640X480 =
      '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam timing_t T_800X600 =
      '{800, 56, 120, 64, 600, 37, 6, 23};
   localparam timing_t T_320X240 =
      '{8, 2, 3, 1, 4, 1, 1, 1};

   function automatic int total(
      input int active,
      input int fp,
      input int sync,
      input int bp
   );
      return active + fp + sync + bp;
   endfunction

   // True when lo <= v < lo+width.
   function automatic logic in_range(
      input int v,
      input int lo,
      input int width
   );
      return (v >= lo) && (v < lo + width);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Output bundle of the VGA timing generator.
// master: generator drives sync/position/strobes; slave: pixel logic.
interface vga_timing_gen_if #(
   parameter int CW      = 10,
   parameter int FRAME_W = 8
);
   logic               h_sync;
   logic               v_sync;
   logic               video_on;
   logic [CW-1:0]      pixel_x;
   logic [CW-1:0]      pixel_y;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_count;

   modport master (
      output h_sync, v_sync, video_on,
      output pixel_x, pixel_y,
      output line_start, frame_start,
      output frame_count
   );

   modport slave (
      input h_sync, v_sync, video_on,
      input pixel_x, pixel_y,
      input line_start, frame_start,
      input frame_count
   );
endinterface

// File: rtl/vga_timing_gen_axis.sv
// One axis (h or v) of the timing generator: wrapping position counter
// plus combinational active/sync decode. Ports: clk, reset (sync, low),
// step (advance), count, wrap (at last position), active, sync.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter bit POL    = 1'b0,
   parameter int CW     = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          active,
   output logic          sync
);

   localparam int TOTAL = total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

   if ((TOTAL - 1) > (2**CW - 1) || SYNC == 0 || ACTIVE == 0)
   begin : g_bad_timing
      $error("vga_axis_counter: bad timing for CW");
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (step) begin
         count <= wrap ? '0 : count + CW'(1);
      end
   end

   assign wrap   = (count == LAST);
   assign active = in_range(int'(count), 0, ACTIVE);
   assign sync   = in_range(int'(count), ACTIVE + FP, SYNC)
                   ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/position generator with pixel enable.
// Ports: clock25, reset (sync, low), pix_en, vga (master bundle).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = T_640X480.h_active,
   parameter int H_FP     = T_640X480.h_fp,
   parameter int H_SYNC   = T_640X480.h_sync,
   parameter int H_BP     = T_640X480.h_bp,
   parameter int V_ACTIVE = T_640X480.v_active,
   parameter int V_FP     = T_640X480.v_fp,
   parameter int V_SYNC   = T_640X480.v_sync,
   parameter int V_BP     = T_640X480.v_bp,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 10,
   parameter int FRAME_W  = 8
) (
   input  logic       clock25,
   input  logic       reset,
   input  logic       pix_en,
   vga_timing_gen_if.master vga
);

   logic [CW-1:0] w_hx;
   logic [CW-1:0] w_vy;
   logic          w_h_wrap;
   logic          w_h_act;
   logic          w_h_sync;
   logic          w_v_wrap;
   logic          w_v_act;
   logic          w_v_sync;
   logic          w_v_step;
   logic          w_origin;

   // Vertical advances only on the last pixel of an enabled line.
   assign w_v_step = pix_en & w_h_wrap;
   assign w_origin = (w_hx == '0) && (w_vy == '0);

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .CW     (CW)
   ) u_h (
      .clk    (clock25),
      .reset  (reset),
      .step   (pix_en),
      .count  (w_hx),
      .wrap   (w_h_wrap),
      .active (w_h_act),
      .sync   (w_h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .CW     (CW)
   ) u_v (
      .clk    (clock25),
      .reset  (reset),
      .step   (w_v_step),
      .count  (w_vy),
      .wrap   (w_v_wrap),
      .active (w_v_act),
      .sync   (w_v_sync)
   );

   // Everything is registered from the same (hx, vy) so sync and
   // position never skew; strobes clear on idle cycles.
   always_ff @(posedge clock25) begin
      if (!reset) begin
         vga.h_sync      <= ~HS_POL;
         vga.v_sync      <= ~VS_POL;
         vga.video_on    <= 1'b0;
         vga.pixel_x     <= '0;
         vga.pixel_y     <= '0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
         vga.frame_count <= '0;
      end else begin
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
         if (pix_en) begin
            vga.h_sync      <= w_h_sync;
            vga.v_sync      <= w_v_sync;
            vga.video_on    <= w_h_act & w_v_act;
            vga.pixel_x     <= w_hx;
            vga.pixel_y     <= w_vy;
            vga.line_start  <= (w_hx == '0);
            vga.frame_start <= w_origin;
            if (w_origin) begin
               vga.frame_count <= vga.frame_count + FRAME_W'(1);
            end
         end
      end
   end

   logic w_unused;
   assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance and tiny test-mode instance
// driven by shared reset/pix_en, checked against an arithmetic model.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vo;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic pix_en;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.CW(10), .FRAME_W(8)) if_d ();
   vga_timing_gen_if #(.CW(10), .FRAME_W(2)) if_s ();

   vga_timing_gen u_dflt (
      .clock25 (clk),
      .reset   (rst_n),
      .pix_en  (pix_en),
      .vga     (if_d)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL (1'b1), .VS_POL (1'b1),
      .CW (10), .FRAME_W (2)
   ) u_small (
      .clock25 (clk),
      .reset   (rst_n),
      .pix_en  (pix_en),
      .vga     (if_s)
   );

   int prm [2][8];
   bit hpol [2];
   bit vpol [2];
   int fw [2];
   int kcnt [2];
   exp_t hold [2];
   exp_t q0 [$];
   exp_t q1 [$];
   int checks = 0;
   int errors = 0;

   // Expected output for the k-th enabled pixel since reset.
   function automatic exp_t calc(input int i, input int k);
      exp_t e;
      int ht, vt, x, y, f;
      ht = prm[i][0] + prm[i][1] + prm[i][2] + prm[i][3];
      vt = prm[i][4] + prm[i][5] + prm[i][6] + prm[i][7];
      x = k % ht;
      y = (k / ht) % vt;
      f = (k / (ht * vt) + 1) % (1 << fw[i]);
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.vo = (x < prm[i][0]) && (y < prm[i][4]);
      e.hs = (x >= prm[i][0] + prm[i][1] &&
              x < prm[i][0] + prm[i][1] + prm[i][2])
             ? hpol[i] : ~hpol[i];
      e.vs = (y >= prm[i][4] + prm[i][5] &&
              y < prm[i][4] + prm[i][5] + prm[i][6])
             ? vpol[i] : ~vpol[i];
      e.ls = (x == 0);
      e.fs = (x == 0) && (y == 0);
      e.fc = 8'(f);
      return e;
   endfunction

   function automatic exp_t next_exp(input int i, input bit r,
                                     input bit en);
      exp_t e;
      if (!r) begin
         e = '0;
         e.hs = ~hpol[i];
         e.vs = ~vpol[i];
         kcnt[i] = 0;
         hold[i] = e;
      end else if (en) begin
         e = calc(i, kcnt[i]);
         kcnt[i] = kcnt[i] + 1;
         hold[i] = e;
      end else begin
         e = hold[i];
         e.ls = 1'b0;
         e.fs = 1'b0;
      end
      return e;
   endfunction

   task automatic drive(input bit r, input bit en);
      rst_n  = r;
      pix_en = en;
      q0.push_back(next_exp(0, r, en));
      q1.push_back(next_exp(1, r, en));
      @(negedge clk);
   endtask

   function automatic string fmt(input exp_t e);
      return $sformatf("x=%0d y=%0d vo=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                       e.x, e.y, e.vo, e.hs, e.vs, e.ls, e.fs, e.fc);
   endfunction

   function automatic void compare(input string nm, input exp_t e,
                                   input exp_t a);
      checks = checks + 1;
      if (a !== e) begin
         errors = errors + 1;
         $display("FAIL %s @%0t: got %s, expected %s",
                  nm, $time, fmt(a), fmt(e));
      end
   endfunction

   always begin : monitor
      exp_t a;
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
         a.x  = if_d.pixel_x;
         a.y  = if_d.pixel_y;
         a.vo = if_d.video_on;
         a.hs = if_d.h_sync;
         a.vs = if_d.v_sync;
         a.ls = if_d.line_start;
         a.fs = if_d.frame_start;
         a.fc = if_d.frame_count;
         compare("dflt", q0.pop_front(), a);
      end
      if (q1.size() > 0) begin
         a.x  = if_s.pixel_x;
         a.y  = if_s.pixel_y;
         a.vo = if_s.video_on;
         a.hs = if_s.h_sync;
         a.vs = if_s.v_sync;
         a.ls = if_s.line_start;
         a.fs = if_s.frame_start;
         a.fc = 8'(if_s.frame_count);
         compare("small", q1.pop_front(), a);
      end
   end

   initial begin
      prm[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
      prm[1] = '{8, 2, 3, 1, 4, 1, 1, 1};
      hpol[0] = 1'b0; vpol[0] = 1'b0; fw[0] = 8;
      hpol[1] = 1'b1; vpol[1] = 1'b1; fw[1] = 2;
      kcnt[0] = 0; kcnt[1] = 0;
      hold[0] = '0; hold[1] = '0;
      // reset state
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
      // continuous run: >5 small frames, frame_count wraps 1,2,3,0,1
      for (int i = 0; i < 500; i++) drive(1'b1, 1'b1);
      // half-rate enable
      for (int i = 0; i < 400; i++) drive(1'b1, 1'(i % 2 == 0));
      // single-clock reset mid-frame, reset beats pix_en
      drive(1'b0, 1'b1);
      for (int i = 0; i < 120; i++) drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);
      // random enable with rare resets
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 499) != 0),
               1'($urandom_range(0, 3) != 0));
      end
      // long run so the default instance covers many lines
      drive(1'b0, 1'b0);
      for (int i = 0; i < 16000; i++) drive(1'b1, 1'b1);
      pix_en = 1'b0;
      repeat (3) @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: q0=%0d q1=%0d, expected 0",
                  q0.size(), q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator. It produces horizontal and vertical sync, an active-video flag, pixel coordinates, line and frame start strobes, and a frame counter. Timing, sync polarity and counter widths are parameters, and a pixel-enable input lets it run from a fast system clock. It sits between the clock source and the pixel/frame-buffer logic that drives RGB.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, h_sync active level (0 = active-low)
VS_POL, 0, v_sync active level
CW, 10, coordinate/counter width
FRAME_W, 8, frame counter width

Ports:
clock25  in  1  pixel/system clock
reset  in  1  synchronous, active-low reset
pix_en  in  1  clock enable; one pixel advances per cycle with pix_en=1
h_sync  out  1  horizontal sync, polarity HS_POL
v_sync  out  1  vertical sync, polarity VS_POL
video_on  out  1  1 when the output coordinate is inside the active area
pixel_x  out  CW  current output column
pixel_y  out  CW  current output line
line_start  out  1  one-clock strobe when pixel_x=0
frame_start  out  1  one-clock strobe when pixel_x=0 and pixel_y=0
frame_count  out  FRAME_W  count of completed frame starts, wraps

Behaviour:
- Reset is synchronous and active-low on clock25; one clock, no other clock domains.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if any sync or active width is 0.
- Internal counters hx and vy hold the next position to present. Reset sets both to 0.
- On a cycle with pix_en=1:
  - all outputs register the decode of (hx, vy);
  - hx increments; at H_TOTAL-1, hx wraps to 0 and vy increments;
  - at (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- Latency is one clock from the enabled cycle. h_sync, v_sync, video_on, pixel_x and pixel_y always describe the same coordinate in the same cycle; there is no sync-versus-position skew.
- Decode for coordinate (x, y):
  - video_on = (x < H_ACTIVE) and (y < V_ACTIVE).
  - h_sync = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - v_sync = VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for every x of those lines; otherwise ~VS_POL.
  - line_start = (x == 0). frame_start = (x == 0 and y == 0).
- On a cycle with pix_en=0: pixel_x, pixel_y, h_sync, v_sync and video_on hold their values. line_start and frame_start drop to 0, so strobes are exactly one clock wide.
- frame_count increments by 1 (mod 2^FRAME_W) in the same cycle frame_start is asserted.
- Reset values: h_sync=~HS_POL, v_sync=~VS_POL, video_on=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, frame_count=0.
- The first enabled cycle after reset presents (0,0) with video_on=1, line_start=1, frame_start=1, and frame_count becomes 1.
- Reset mid-frame: counters restart from 0 on the next edge and no partial strobe is emitted. Reset takes precedence over pix_en.

Decomposition:
- Package vga_timing_pkg holds:
  - localparam sets for 640x480@60 (default), 800x600@72 and 320x240 test mode;
  - function total(active, fp, sync, bp);
  - function in_range(v, lo, width) for the sync/active decode.
- Sub-module vga_axis_counter, instanced twice (h, v):
  - parameters ACTIVE, FP, SYNC, BP, POL, CW;
  - ports: clk, reset, step, count, wrap, active, sync.
  - Top level wires h.wrap into v.step (gated by pix_en) and registers the outputs.

Test Plan:
- Defaults, pix_en=1 constant, 2 frames -> 800 clocks per line_start, 420000 clocks between frame_start pulses, 307200 video_on cycles per frame, frame_count 1 -> 2.
- Defaults -> h_sync low exactly at pixel_x 656..751 (96 clocks) on each line; v_sync low for all of lines 490..491 (1600 clocks); both high elsewhere.
- pix_en toggling 1,0,1,0 -> same coordinate sequence at half rate; line_start/frame_start each 1 clock wide; outputs held during pix_en=0.
- H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=VS_POL=1 -> H_TOTAL 14, V_TOTAL 7; h_sync high at x=10..12; v_sync high on y=5.
- reset=0 for one clock at (300,200) -> outputs return to reset values; next enabled cycle shows (0,0) with frame_start=1 and frame_count=1.
- FRAME_W=2, small-mode params, 5 frames -> frame_count sequence 1,2,3,0,1.
